// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM states,
// port identifiers and default sizing of the big-endian 16-bit word memory.
package MemArbPkg;

  localparam int MEM_BYTES_DEFAULT = 128;
  localparam int WORD_W            = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_pick.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to the port named by the priority pointer.
module RoundRobinPick2
  import MemArbPkg::*;
(
  input  logic  i_req_a,
  input  logic  i_req_b,
  input  port_e i_prio,
  output logic  o_valid,
  output port_e o_winner
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    o_valid  = i_req_a | i_req_b;
    o_winner = PORT_A;
    if (i_req_a && i_req_b) begin
      o_winner = i_prio;
    end else if (i_req_b) begin
      o_winner = PORT_B;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer in front of the
// big-endian 16-bit-word DataMemory; one access in flight, IDLE->ACCESS->RESP.
module data_mem_arbiter
  import MemArbPkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int AW        = 16,
  parameter int DW        = WORD_W
) (
  input  logic          Clock,
  input  logic          ResetN,

  input  logic          ReqA,
  input  logic          WriteA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] WDataA,
  output logic          DoneA,
  output logic          ErrA,
  output logic [DW-1:0] RDataA,

  input  logic          ReqB,
  input  logic          WriteB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] WDataB,
  output logic          DoneB,
  output logic          ErrB,
  output logic [DW-1:0] RDataB,

  output logic [AW-1:0] MemAddress,
  output logic [DW-1:0] MemWriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] MemReadData
);

  // Highest legal word address: the LSB byte at Addr+1 must still exist.
  localparam logic [AW-1:0] LAST_WORD_ADDR = AW'(MEM_BYTES - 2);

  state_e        r_state;
  state_e        w_state_next;
  port_e         r_prio;
  port_e         r_cmd_port;
  logic          r_cmd_write;
  logic [AW-1:0] r_cmd_addr;
  logic [DW-1:0] r_cmd_wdata;
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;

  logic          w_grant;
  port_e         w_winner;
  logic          w_take_cmd;
  logic          w_err;
  logic          w_sel_write;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [DW-1:0] w_load_data;

  RoundRobinPick2 u_pick (
    .i_req_a  (ReqA),
    .i_req_b  (ReqB),
    .i_prio   (r_prio),
    .o_valid  (w_grant),
    .o_winner (w_winner)
  );

  assign w_sel_write = (w_winner == PORT_A) ? WriteA : WriteB;
  assign w_sel_addr  = (w_winner == PORT_A) ? AddrA  : AddrB;
  assign w_sel_wdata = (w_winner == PORT_A) ? WDataA : WDataB;

  assign w_err       = (r_cmd_addr > LAST_WORD_ADDR);
  assign w_load_data = w_err ? '0 : MemReadData;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= IDLE;
      r_prio      <= PORT_A;
      r_cmd_port  <= PORT_A;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take_cmd) begin
        r_cmd_port  <= w_winner;
        r_prio      <= other_port(w_winner);
        r_cmd_write <= w_sel_write;
        r_cmd_addr  <= w_sel_addr;
        r_cmd_wdata <= w_sel_wdata;
      end
    end
  end

  // Loads and rejected accesses update the winner's read-data register at the
  // end of ACCESS; a good store leaves it alone.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else if (r_state == ACCESS && (w_err || !r_cmd_write)) begin
      if (r_cmd_port == PORT_A) begin
        r_rdata_a <= w_load_data;
      end else begin
        r_rdata_b <= w_load_data;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take_cmd   = 1'b0;
    MemAddress   = '0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    DoneA        = 1'b0;
    DoneB        = 1'b0;
    ErrA         = 1'b0;
    ErrB         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_take_cmd   = 1'b1;
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        MemAddress   = r_cmd_addr;
        MemWrite     = r_cmd_write & ~w_err;
        MemRead      = ~r_cmd_write & ~w_err;
        w_state_next = RESP;
      end
      RESP: begin
        DoneA        = (r_cmd_port == PORT_A);
        DoneB        = (r_cmd_port == PORT_B);
        ErrA         = (r_cmd_port == PORT_A) & w_err;
        ErrB         = (r_cmd_port == PORT_B) & w_err;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign MemWriteData = r_cmd_wdata;
  assign RDataA       = r_rdata_a;
  assign RDataB       = r_rdata_b;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 128-byte big-endian
// DataMemory; expected values are hand-computed from the initial byte pattern.
module tb_data_mem_arbiter;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        ReqA, WriteA, ReqB, WriteB;
  logic [15:0] AddrA, WDataA, AddrB, WDataB;
  logic        DoneA, ErrA, DoneB, ErrB;
  logic [15:0] RDataA, RDataB;
  logic [15:0] MemAddress, MemWriteData, MemReadData;
  logic        MemWrite, MemRead;

  always #5 Clock = ~Clock;

  data_mem_arbiter dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .ReqA         (ReqA),
    .WriteA       (WriteA),
    .AddrA        (AddrA),
    .WDataA       (WDataA),
    .DoneA        (DoneA),
    .ErrA         (ErrA),
    .RDataA       (RDataA),
    .ReqB         (ReqB),
    .WriteB       (WriteB),
    .AddrB        (AddrB),
    .WDataB       (WDataB),
    .DoneB        (DoneB),
    .ErrB         (ErrB),
    .RDataB       (RDataB),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  // Memory model: byte i initialised to i, big-endian word at Addr/Addr+1.
  logic [7:0] mem [0:127];
  logic       mem_init;

  always @(posedge Clock) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
    end else if (MemWrite && MemAddress < 16'd127) begin
      mem[MemAddress[6:0]]        <= MemWriteData[15:8];
      mem[MemAddress[6:0] + 7'd1] <= MemWriteData[7:0];
    end
  end

  assign MemReadData = (MemAddress < 16'd127) ?
                       {mem[MemAddress[6:0]], mem[MemAddress[6:0] + 7'd1]} : 16'h0000;

  int          n_wr = 0;
  int          n_done_a = 0;
  logic [15:0] last_addr = 16'h0;

  always @(negedge Clock) begin
    if (MemWrite) begin
      n_wr      <= n_wr + 1;
      last_addr <= MemAddress;
    end
    if (DoneA) n_done_a <= n_done_a + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic outputs_zero(input string pfx);
    check({pfx, "_DoneA"},        32'(DoneA),        0);
    check({pfx, "_ErrA"},         32'(ErrA),         0);
    check({pfx, "_RDataA"},       32'(RDataA),       0);
    check({pfx, "_DoneB"},        32'(DoneB),        0);
    check({pfx, "_ErrB"},         32'(ErrB),         0);
    check({pfx, "_RDataB"},       32'(RDataB),       0);
    check({pfx, "_MemAddress"},   32'(MemAddress),   0);
    check({pfx, "_MemWriteData"}, 32'(MemWriteData), 0);
    check({pfx, "_MemWrite"},     32'(MemWrite),     0);
    check({pfx, "_MemRead"},      32'(MemRead),      0);
  endtask

  logic [15:0] rd_a, rd_b;
  logic        er_a, er_b;

  // Issue requests at a negedge in IDLE; report the negedge count at which
  // each Done is seen (-1 if never), dropping Req on Done.
  task automatic run_txn(input logic en_a, input logic wa, input logic [15:0] aa, input logic [15:0] da,
                         input logic en_b, input logic wb, input logic [15:0] ab, input logic [15:0] db,
                         output int cyc_a, output int cyc_b);
    cyc_a = -1;
    cyc_b = -1;
    @(negedge Clock);
    ReqA = en_a; WriteA = wa; AddrA = aa; WDataA = da;
    ReqB = en_b; WriteB = wb; AddrB = ab; WDataB = db;
    for (int n = 1; n <= 30 && ((en_a && cyc_a < 0) || (en_b && cyc_b < 0)); n++) begin
      @(negedge Clock);
      if (DoneA) begin cyc_a = n; rd_a = RDataA; er_a = ErrA; ReqA = 1'b0; end
      if (DoneB) begin cyc_b = n; rd_b = RDataB; er_b = ErrB; ReqB = 1'b0; end
    end
    ReqA = 1'b0;
    ReqB = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    ResetN = 1'b0;
    @(negedge Clock);
    ResetN = 1'b1;
  endtask

  initial begin
    int ca, cb, wr0, done0, first, second;
    logic [15:0] rd1, rd2;

    ResetN = 1'b0; mem_init = 1'b1;
    ReqA = 1'b0; WriteA = 1'b0; AddrA = '0; WDataA = '0;
    ReqB = 1'b0; WriteB = 1'b0; AddrB = '0; WDataB = '0;
    repeat (3) @(negedge Clock);
    outputs_zero("reset");
    ResetN = 1'b1;
    mem_init = 1'b0;

    // Single store then load on A.
    wr0 = n_wr;
    run_txn(1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0, ca, cb);
    check("wr_latency", 32'(ca), 2);
    check("wr_err", 32'(er_a), 0);
    check("wr_pulses", 32'(n_wr - wr0), 1);
    check("wr_addr", 32'(last_addr), 32'h10);
    check("mem_0x10", 32'(mem[16]), 32'hBE);
    check("mem_0x11", 32'(mem[17]), 32'hEF);
    run_txn(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, ca, cb);
    check("rd_latency", 32'(ca), 2);
    check("rd_data", 32'(rd_a), 32'hBEEF);
    check("rd_err", 32'(er_a), 0);
    repeat (3) @(negedge Clock);
    check("rd_hold", 32'(RDataA), 32'hBEEF);

    // Simultaneous requests after reset: A first, B three cycles later.
    pulse_reset();
    run_txn(1, 0, 16'h0000, 16'h0, 1, 1, 16'h0020, 16'h1234, ca, cb);
    check("pair1_a_cyc", 32'(ca), 2);
    check("pair1_b_cyc", 32'(cb), 5);
    check("pair1_a_data", 32'(rd_a), 32'h0001);
    check("pair1_b_err", 32'(er_b), 0);
    check("mem_0x20", 32'(mem[32]), 32'h12);
    check("mem_0x21", 32'(mem[33]), 32'h34);
    // Lone A grant leaves the pointer at B, so the next tie goes to B.
    run_txn(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0, ca, cb);
    check("lone_a_data", 32'(rd_a), 32'h1234);
    run_txn(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0, ca, cb);
    check("pair2_b_cyc", 32'(cb), 2);
    check("pair2_a_cyc", 32'(ca), 5);
    check("pair2_a_data", 32'(rd_a), 32'hBEEF);
    check("pair2_b_data", 32'(rd_b), 32'h1234);

    // Back-to-back on B: Req held through Done with a new address.
    first = -1; second = -1; rd1 = '0; rd2 = '0;
    @(negedge Clock);
    ReqB = 1'b1; WriteB = 1'b0; AddrB = 16'h0010;
    for (int n = 1; n <= 30 && second < 0; n++) begin
      @(negedge Clock);
      if (DoneB) begin
        if (first < 0) begin first = n; rd1 = RDataB; AddrB = 16'h0020; end
        else begin second = n; rd2 = RDataB; ReqB = 1'b0; end
      end
    end
    ReqB = 1'b0;
    check("b2b_first_cyc", 32'(first), 2);
    check("b2b_second_cyc", 32'(second), 5);
    check("b2b_first_data", 32'(rd1), 32'hBEEF);
    check("b2b_second_data", 32'(rd2), 32'h1234);

    // Highest legal word address.
    run_txn(1, 0, 16'd126, 16'h0, 0, 0, 16'h0, 16'h0, ca, cb);
    check("bound_err", 32'(er_a), 0);
    check("bound_data", 32'(rd_a), 32'h7E7F);

    // Out-of-range stores: flagged, memory untouched, RData cleared.
    wr0 = n_wr;
    run_txn(1, 1, 16'd127, 16'h5555, 0, 0, 16'h0, 16'h0, ca, cb);
    check("oor127_cyc", 32'(ca), 2);
    check("oor127_err", 32'(er_a), 1);
    check("oor127_rdata", 32'(rd_a), 0);
    check("mem_0x7f", 32'(mem[127]), 32'h7F);
    run_txn(1, 1, 16'h0100, 16'h5555, 0, 0, 16'h0, 16'h0, ca, cb);
    check("oor100_err", 32'(er_a), 1);
    check("oor100_rdata", 32'(rd_a), 0);
    check("oor_no_write", 32'(n_wr - wr0), 0);

    // Reset asserted mid-ACCESS of a store.
    @(negedge Clock);
    ReqA = 1'b1; WriteA = 1'b1; AddrA = 16'h0040; WDataA = 16'hAAAA;
    @(negedge Clock);
    check("mid_memwrite", 32'(MemWrite), 1);
    ResetN = 1'b0;
    #1;
    outputs_zero("rst_mid");
    @(negedge Clock);
    ReqA = 1'b0;
    ResetN = 1'b1;
    done0 = n_done_a;
    repeat (4) @(negedge Clock);
    check("mid_no_done", 32'(n_done_a - done0), 0);
    check("mem_0x40", 32'(mem[64]), 32'h40);
    check("mem_0x41", 32'(mem[65]), 32'h41);
    run_txn(1, 0, 16'h0040, 16'h0, 1, 0, 16'h0010, 16'h0, ca, cb);
    check("post_rst_a_cyc", 32'(ca), 2);
    check("post_rst_b_cyc", 32'(cb), 5);
    check("post_rst_a_data", 32'(rd_a), 32'h4041);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

- Two-requester arbiter and sequencer in front of the 128-byte, big-endian, 16-bit-word `DataMemory`.
- Requesters:
  - Port A: processor load/store path.
  - Port B: debug/loader path.
- Arbitration is round-robin between the two ports, with one memory access in flight at a time.
- The block range-checks addresses and sequences the memory's `MemRead`/`MemWrite`/`Address`/`WriteData` pins.

## Interface
Parameters:
- `MEM_BYTES`, default 128: size of the backing byte array.
- `AW`, default 16: address width.
- `DW`, default 16: data width, fixed to 2 bytes.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `Clock`, in, 1: rising-edge clock shared with `DataMemory`.
  - `ResetN`, in, 1: asynchronous active-low reset.
- Port A (processor):
  - `ReqA`, in, 1: access request, held until `DoneA`.
  - `WriteA`, in, 1: 1 = store, 0 = load; stable while `ReqA`.
  - `AddrA`, in, AW: byte address of the big-endian word.
  - `WDataA`, in, DW: store data.
  - `DoneA`, out, 1: one-cycle completion pulse.
  - `ErrA`, out, 1: valid with `DoneA`; set when the address is out of range.
  - `RDataA`, out, DW: load data; valid with `DoneA` and held until the next `DoneA`.
- Port B (debug/loader): `ReqB`, `WriteB`, `AddrB`, `WDataB`, `DoneB`, `ErrB`, `RDataB`, identical to port A.
- Memory side:
  - `MemAddress`, out, AW.
  - `MemWriteData`, out, DW.
  - `MemWrite`, out, 1.
  - `MemRead`, out, 1.
  - `MemReadData`, in, DW: combinational read data from `DataMemory`.

## Operation
- FSM states: `IDLE` → `ACCESS` → `RESP` → `IDLE`.
- `IDLE`:
  - If neither request is asserted, stay in `IDLE`.
  - Otherwise pick a winner:
    - If only one request is asserted, that port wins.
    - If both are asserted, the port the pointer `Prio` indicates wins.
  - Latch the winner's write flag, address, data and port ID into command registers.
  - Set `Prio` to the other port. Go to `ACCESS`.
- Range check, evaluated on the latched address: `Err = (Addr > MEM_BYTES-2)`. The `Addr+1` byte must exist.
- `ACCESS`, for one cycle:
  - `MemAddress` = latched address. `MemWriteData` = latched data.
  - Write with `Err`=0: `MemWrite`=1.
  - Read with `Err`=0: `MemRead`=1, and `MemReadData` is captured into the winner's `RData` register at the closing edge.
  - `Err`=1: `MemWrite`=0 and `MemRead`=0. Memory is untouched and `RData` is loaded with 0.
  - Go to `RESP`.
- `RESP`: assert `Done`/`Err` for the winning port only, for one cycle. Go to `IDLE`.
- Outside `ACCESS`: `MemWrite`=0, `MemRead`=0, `MemAddress`=0. `MemWriteData` holds its last value.
- Requester rule:
  - Deassert `Req` at the edge where `Done` is sampled high.
  - A `Req` still high in `IDLE` is treated as a new request.
  - `Req`, `Write`, `Addr` and `WData` changes during `ACCESS`/`RESP` are ignored, because the command is already latched.
  - Dropping `Req` before `Done` does not cancel the access.
- Odd addresses are legal. The word spans bytes `Addr` (MSB) and `Addr+1` (LSB), with no alignment check.

## Timing
- Latency:
  - `Req` sampled high at edge N (FSM in `IDLE`) → `ACCESS` during cycle N..N+1.
  - Write commits to memory at edge N+1.
  - `Done` is high during cycle N+1..N+2.
- Throughput:
  - One access per 3 cycles.
  - Both ports continuously requesting alternate A, B, A, …
  - Each port completes once per 6 cycles.
- Reset value of every output is 0: `DoneA/B`, `ErrA/B`, `RDataA/B`, `MemAddress`, `MemWriteData`, `MemWrite`, `MemRead`. Reset also sets `Prio` to A and the state to `IDLE`.
- Reset during `ACCESS`:
  - `MemWrite` drops asynchronously, so the write is suppressed if `ResetN` is low at the edge.
  - No `Done` is issued and the requester must re-request.
- Reset during `RESP`: the `Done` pulse is truncated.

## Structure
- Shared package `MemArbPkg` holds:
  - the state encoding `IDLE`/`ACCESS`/`RESP`;
  - the port ID constants `PORT_A`=0 and `PORT_B`=1;
  - `MEM_BYTES_DEFAULT`=128;
  - the word width constant.
- One sub-module, `RoundRobinPick2`: combinational winner selection from `ReqA`, `ReqB` and `Prio`. The `Prio` register stays in the top-level block.
- All other logic (FSM, command registers, range check, response registers) is in `data_mem_arbiter`.

## Test plan
- Single write then read on A:
  - Stimulus: write `AddrA`=0x0010, `WDataA`=0xBEEF, then read 0x0010.
  - Response: `MemWrite` is 1 for exactly one cycle; `DoneA` fires 2 cycles after `ReqA` is sampled; `RDataA`=0xBEEF; byte 0x10=0xBE, byte 0x11=0xEF.
- Simultaneous requests:
  - Stimulus: `ReqA` and `ReqB` rise in the same cycle after reset; A reads 0x0000, B writes 0x1234 to 0x0020.
  - Response: A is served first, then B; `DoneB` fires 3 cycles after `DoneA`; a second simultaneous pair is served B first.
- Boundary address:
  - Stimulus: read at `AddrA`=126.
  - Response: `ErrA`=0, with data from bytes 126/127.
- Out-of-range address:
  - Stimulus: write at `AddrA`=127, then at 0x0100.
  - Response: `ErrA`=1 with `DoneA`, `MemWrite` never asserts, memory is unchanged, `RDataA`=0.
- Back-to-back requests: B holds `ReqB` high through `DoneB` with a new address → the second access starts in the following `IDLE` cycle, at 3-cycle spacing.
- Reset mid-access:
  - Stimulus: pulse `ResetN` low during `ACCESS` of a write of 0xAAAA to 0x0040.
  - Response: byte 0x40 is unchanged, no `DoneA`, all outputs are 0, and the next contended grant goes to A.
